// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port synchronous RAM.
package dp_ram_pkg;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/dp_ram_port.sv
// One RAM port's output stage: registered read data, rvalid and read-during-write select.
module dp_ram_port
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] new_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              rvalid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              rvalid_q;

  always_comb begin
    data_d = data_q;
    if (acc_i) begin
      data_d = (we_i && (RDW_MODE == RDW_WRITE_FIRST)) ? new_i : old_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      rvalid_q <= acc_i;
    end
  end

  assign data_out_o = data_q;
  assign rvalid_o   = rvalid_q;

endmodule

// File: rtl/dp_ram_sync.sv
// True dual-port RAM with byte enables, port-A write priority and collision flag.
// Define DP_RAM_CLEAR_EN to zero the array with a sweep after every reset.
module dp_ram_sync
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_a,
  input  logic                en_b,
  input  logic                we_a,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_in_a,
  input  logic [DATA_W-1:0]   data_in_b,
  output logic [DATA_W-1:0]   data_out_a,
  output logic [DATA_W-1:0]   data_out_b,
  output logic                rvalid_a,
  output logic                rvalid_b,
  output logic                collision,
  output logic                init_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e state_q;
  logic   busy_q;
  logic   coll_q;
`ifdef DP_RAM_CLEAR_EN
  logic [ADDR_W-1:0] cnt_q;
`endif

  logic              ready, same, acc_a, acc_b, wr_a, wr_b;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b;

  assign ready = (state_q == StReady);
  assign acc_a = ready & en_a;
  assign acc_b = ready & en_b;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;
  assign same  = (addr_a == addr_b);
  assign old_a = mem_q[addr_a];
  assign old_b = mem_q[addr_b];

  // Merged post-write words; on a same-address dual write both equal the stored result.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && be_a[i]) begin
        new_a[i*8 +: 8] = data_in_a[i*8 +: 8];
      end else if (wr_b && same && be_b[i]) begin
        new_a[i*8 +: 8] = data_in_b[i*8 +: 8];
      end
      if (wr_a && same && be_a[i]) begin
        new_b[i*8 +: 8] = data_in_a[i*8 +: 8];
      end else if (wr_b && be_b[i]) begin
        new_b[i*8 +: 8] = data_in_b[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
`ifdef DP_RAM_CLEAR_EN
    if (state_q == StInit) begin
      mem_q[cnt_q] <= '0;
    end
`endif
    if (wr_a) begin
      mem_q[addr_a] <= new_a;
    end
    if (wr_b && !(wr_a && same)) begin
      mem_q[addr_b] <= new_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DP_RAM_CLEAR_EN
      state_q <= StInit;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
`else
      state_q <= StReady;
      busy_q  <= 1'b0;
`endif
      coll_q  <= 1'b0;
    end else begin
      coll_q <= wr_a & wr_b & same & (|(be_a & be_b));
`ifdef DP_RAM_CLEAR_EN
      if (state_q == StInit) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= StReady;
          busy_q  <= 1'b0;
        end
      end
`endif
    end
  end

  assign collision = coll_q;
  assign init_busy = busy_q;

  dp_ram_port #(
    .DATA_W  (DATA_W),
    .RDW_MODE(RDW_MODE)
  ) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_i     (acc_a),
    .we_i      (we_a),
    .old_i     (old_a),
    .new_i     (new_a),
    .data_out_o(data_out_a),
    .rvalid_o  (rvalid_a)
  );

  dp_ram_port #(
    .DATA_W  (DATA_W),
    .RDW_MODE(RDW_MODE)
  ) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_i     (acc_b),
    .we_i      (we_b),
    .old_i     (old_b),
    .new_i     (new_b),
    .data_out_o(data_out_b),
    .rvalid_o  (rvalid_b)
  );

endmodule

// File: doc/dp_ram_sync.md
DP_RAM_SYNC -- requirements
Module: dp_ram_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter RDW_MODE, default 0: same-port read-during-write (0 = read-first/old data, 1 = write-first/new data).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports en_a/en_b, input, 1 bit each: port access request.
REQ-007 SHALL have ports we_a/we_b, input, 1 bit each: write when en_x=1, else read.
REQ-008 SHALL have ports be_a/be_b, input, DATA_W/8 bits each: per-byte write enables.
REQ-009 SHALL have ports addr_a/addr_b, input, ADDR_W bits each: word address.
REQ-010 SHALL have ports data_in_a/data_in_b, input, DATA_W bits each: write data.
REQ-011 SHALL have ports data_out_a/data_out_b, output, DATA_W bits each: registered read data.
REQ-012 SHALL have ports rvalid_a/rvalid_b, output, 1 bit each: data_out_x valid this cycle.
REQ-013 SHALL have port collision, output, 1 bit: one-cycle pulse on a dual-write address clash.
REQ-014 SHALL have port init_busy, output, 1 bit: clear sequence in progress; requests ignored.

Function
REQ-015 SHALL perform a read (en_x=1, we_x=0) with 1-cycle latency: data_out_x and rvalid_x=1 on the next edge.
REQ-016 SHALL hold data_out_x while rvalid_x=0.
REQ-017 SHALL perform a write (en_x=1, we_x=1) only on byte lanes with be_x[i]=1; other lanes unchanged.
REQ-018 SHALL make a write also drive rvalid_x=1 one cycle later, with data_out_x per RDW_MODE: old word (0) or post-write merged word (1).
REQ-019 SHALL give A priority when both ports write the same address in one cycle: per lane, A's enabled bytes win; B writes only lanes where be_a=0 and be_b=1; collision=1 on the next cycle.
REQ-020 SHALL assert collision only when both ports write the same address with overlapping byte enables.
REQ-021 SHALL return the pre-write word to a read on one port when the other port writes the same address in the same cycle.
REQ-022 SHALL implement FSM states INIT and READY: INIT sweeps a counter 0..DEPTH-1 writing zero words (DEPTH cycles), then goes to READY; READY is terminal until reset.
REQ-023 SHALL ignore en_a/en_b during INIT: no writes, rvalid_x=0, collision=0.
REQ-024 SHALL wrap the address modulo DEPTH; no out-of-range accesses exist.

Reset
REQ-025 SHALL, on rst_n low, immediately drive data_out_x=0, rvalid_x=0, collision=0, clear the sweep counter, and enter INIT (with DP_RAM_CLEAR_EN) or READY (without).
REQ-026 SHALL, on reset mid-sweep or mid-access, abandon the operation and restart the sweep at address 0 after release; array cells are not touched asynchronously.

Configuration
REQ-027 SHALL, with macro DP_RAM_CLEAR_EN defined, include the INIT sweep, with init_busy=1 from reset until the cycle READY is entered.
REQ-028 SHALL, without DP_RAM_CLEAR_EN, omit the sweep: init_busy tied 0, contents undefined after reset, accesses accepted on the first cycle after release.

Structure
REQ-029 SHALL import package dp_ram_pkg, which holds the FSM state enum and the RDW_MODE constants RDW_READ_FIRST and RDW_WRITE_FIRST.
REQ-030 SHALL instantiate sub-module dp_ram_port twice, once per port; each instance holds the output data register, rvalid and RDW selection.
REQ-031 SHALL keep the array, collision merge and FSM in the top level.

Verification
REQ-032 SHALL cover write-then-read: A writes 0xAA to addr 0 with be=1; next cycle B reads addr 0 -> after 1 cycle data_out_b=0xAA, rvalid_b=1.
REQ-033 SHALL cover collision: DATA_W=16; A writes 0x1234 with be=2'b01 and B writes 0xABCD with be=2'b11, both to addr 5 -> collision pulses once; a later read of addr 5 gives 0xAB34.
REQ-034 SHALL cover RDW modes: addr 2 holds 0x11; port A writes 0x22 to addr 2 -> data_out_a=0x11 with RDW_MODE=0 and 0x22 with RDW_MODE=1.
REQ-035 SHALL cover clear (DP_RAM_CLEAR_EN, ADDR_W=3): after reset, init_busy stays high 8 cycles; a request issued during it gives no rvalid; afterwards all 8 addresses read 0x00.
REQ-036 SHALL cover reset mid-sweep: assert rst_n low at sweep cycle 4 -> outputs 0 immediately; after release init_busy stays high a full 8 cycles.
